// File: rtl/gate_vector_checker_pkg.sv
// Shared definitions for the gate checker family: FSM states, y bit layout
// and vector count.
package gate_vector_checker_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_CHECK  = 2'd2,
    ST_DONE   = 2'd3
  } state_t;

  localparam int Y_AND  = 0;
  localparam int Y_OR   = 1;
  localparam int Y_NOTA = 2;
  localparam int Y_NAND = 3;
  localparam int Y_NOR  = 4;
  localparam int Y_XOR  = 5;
  localparam int Y_XNOR = 6;
  localparam int Y_W    = 7;

  localparam int NUM_VEC = 4;
  localparam int VEC_W   = 2;

endpackage

// File: rtl/gate_vector_checker_if.sv
// Stimulus/response and status bundle between the checker and its surroundings.
interface gate_vector_checker_if #(
  parameter int ERR_W = 3
);
  import gate_vector_checker_pkg::*;

  logic             start;
  logic [Y_W-1:0]   y;
  logic             a;
  logic             b;
  logic             busy;
  logic             done;
  logic             pass;
  logic [ERR_W-1:0] err_count;
  logic             fail_valid;
  logic [VEC_W-1:0] fail_vec;
  logic [Y_W-1:0]   fail_mask;

  modport master (
    output start, y,
    input  a, b, busy, done, pass, err_count, fail_valid, fail_vec, fail_mask
  );

  modport slave (
    input  start, y,
    output a, b, busy, done, pass, err_count, fail_valid, fail_vec, fail_mask
  );

endinterface

// File: rtl/gate_ref_model.sv
// Golden response of the 2-input gate block; purely combinational.
module gate_ref_model
  import gate_vector_checker_pkg::*;
(
  input  logic           a,
  input  logic           b,
  output logic [Y_W-1:0] exp_y
);

  always_comb begin
    exp_y         = '0;
    exp_y[Y_AND]  = a & b;
    exp_y[Y_OR]   = a | b;
    exp_y[Y_NOTA] = ~a;
    exp_y[Y_NAND] = ~(a & b);
    exp_y[Y_NOR]  = ~(a | b);
    exp_y[Y_XOR]  = a ^ b;
    exp_y[Y_XNOR] = ~(a ^ b);
  end

endmodule

// File: rtl/gate_vector_checker.sv
// Walks {a,b} through 00..11, lets the gate block settle, checks y against
// the golden model and reports error count, first failure and pass/done.
module gate_vector_checker
  import gate_vector_checker_pkg::*;
#(
  parameter int SETTLE_CYCLES = 2,
  parameter int ERR_W         = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  gate_vector_checker_if.slave  bus
);

  localparam int CNT_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;

  state_t           state_q, state_d;
  logic [VEC_W-1:0] vec_q;
  logic [CNT_W-1:0] settle_cnt;
  logic [ERR_W-1:0] err_q;
  logic             busy_q, done_q, pass_q, fvalid_q;
  logic [VEC_W-1:0] fvec_q;
  logic [Y_W-1:0]   fmask_q;
  logic [Y_W-1:0]   exp_y, diff;
  logic             mismatch, settle_last, last_vec;

  gate_ref_model u_ref (
    .a     (vec_q[1]),
    .b     (vec_q[0]),
    .exp_y (exp_y)
  );

  assign diff        = bus.y ^ exp_y;
  assign mismatch    = |diff;
  assign settle_last = (settle_cnt == CNT_W'(SETTLE_CYCLES - 1));
  assign last_vec    = (vec_q == VEC_W'(NUM_VEC - 1));

  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:   if (bus.start) state_d = ST_SETTLE;
      ST_SETTLE: if (settle_last) state_d = ST_CHECK;
      ST_CHECK:  state_d = last_vec ? ST_DONE : ST_SETTLE;
      ST_DONE:   state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      vec_q      <= '0;
      settle_cnt <= '0;
      err_q      <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      pass_q     <= 1'b0;
      fvalid_q   <= 1'b0;
      fvec_q     <= '0;
      fmask_q    <= '0;
    end else begin
      unique case (state_q)
        ST_IDLE: if (bus.start) begin
          vec_q      <= '0;
          settle_cnt <= '0;
          err_q      <= '0;
          busy_q     <= 1'b1;
          done_q     <= 1'b0;
          pass_q     <= 1'b0;
          fvalid_q   <= 1'b0;
          fvec_q     <= '0;
          fmask_q    <= '0;
        end
        ST_SETTLE: settle_cnt <= settle_last ? '0 : settle_cnt + CNT_W'(1);
        ST_CHECK: begin
          if (mismatch) begin
            if (err_q != '1) err_q <= err_q + ERR_W'(1);
            if (!fvalid_q) begin
              fvalid_q <= 1'b1;
              fvec_q   <= vec_q;
              fmask_q  <= diff;
            end
          end
          if (!last_vec) vec_q <= vec_q + VEC_W'(1);
        end
        // err_q already includes the last vector's result by the time DONE runs
        ST_DONE: begin
          done_q <= 1'b1;
          busy_q <= 1'b0;
          pass_q <= (err_q == '0);
        end
        default: ;
      endcase
    end
  end

  assign bus.a          = vec_q[1];
  assign bus.b          = vec_q[0];
  assign bus.busy       = busy_q;
  assign bus.done       = done_q;
  assign bus.pass       = pass_q;
  assign bus.err_count  = err_q;
  assign bus.fail_valid = fvalid_q;
  assign bus.fail_vec   = fvec_q;
  assign bus.fail_mask  = fmask_q;

endmodule

// File: tb/tb_gate_vector_checker.sv
// Randomized run sequences against a run-offset reference model, with two
// checkers (ERR_W=3 and ERR_W=1) driven side by side.
module tb_gate_vector_checker;

  localparam int S   = 2;
  localparam int RUN = 4 * (S + 1);  // busy through offset RUN, done from RUN+1

  typedef struct {
    logic       a, b, busy, done, pass, fv;
    int         errs;
    logic [1:0] fvec;
    logic [6:0] fmask;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic [6:0] f_clr = '0, f_inv = '0;
  logic [6:0] m_clr = '0, m_inv = '0;
  int         e = -1;
  bit         cmp_en = 1'b0;
  int         ncmp = 0, nfail = 0;

  always #5 clk = ~clk;

  gate_vector_checker_if #(.ERR_W(3)) bus3 ();
  gate_vector_checker_if #(.ERR_W(1)) bus1 ();

  gate_vector_checker #(.SETTLE_CYCLES(S), .ERR_W(3)) dut3 (.clk(clk), .rst(rst), .bus(bus3));
  gate_vector_checker #(.SETTLE_CYCLES(S), .ERR_W(1)) dut1 (.clk(clk), .rst(rst), .bus(bus1));

  // Truth table of the gate block, bits {xnor,xor,nor,nand,nota,or,and}
  function automatic logic [6:0] gold(input int v);
    case (v)
      0:       return 7'b1011100;
      1:       return 7'b0101110;
      2:       return 7'b0101010;
      default: return 7'b1000011;
    endcase
  endfunction

  // Gate block with optional faults: forced-zero bits and inverted bits
  assign bus3.start = start;
  assign bus1.start = start;
  assign bus3.y = (gold(int'({bus3.a, bus3.b})) & ~f_clr) ^ f_inv;
  assign bus1.y = (gold(int'({bus1.a, bus1.b})) & ~f_clr) ^ f_inv;

  // Expected outputs as a function of the number of edges since the accepted start
  function automatic exp_t model(input int off, input int errmax, input logic [6:0] clr, input logic [6:0] inv);
    exp_t r;
    int chkd, v, n;
    logic [6:0] d;
    r = '{default: 0};
    if (off < 0) return r;
    chkd = off / (S + 1); if (chkd > 4) chkd = 4;
    v    = off / (S + 1); if (v > 3) v = 3;
    r.a    = (v >= 2);
    r.b    = (v % 2 == 1);
    r.busy = (off <= RUN);
    r.done = (off > RUN);
    n = 0;
    for (int k = 0; k < chkd; k++) begin
      d = ((gold(k) & ~clr) ^ inv) ^ gold(k);
      if (d != 0) begin
        n++;
        if (!r.fv) begin r.fv = 1'b1; r.fvec = 2'(k); r.fmask = d; end
      end
    end
    r.errs = (n > errmax) ? errmax : n;
    r.pass = r.done && (n == 0);
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    ncmp++;
    if (act !== expv) begin
      nfail++;
      if (nfail <= 30) $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, expv, $time);
    end
  endtask

  always @(posedge clk) begin
    if (rst) e <= -1;
    else if (start && (e < 0 || e > RUN)) begin
      e <= 0; m_clr <= f_clr; m_inv <= f_inv;
    end else if (e >= 0 && e < 10000) e <= e + 1;
  end

  always @(negedge clk) begin
    exp_t r3, r1;
    if (cmp_en) begin
      r3 = model(e, 7, m_clr, m_inv);
      r1 = model(e, 1, m_clr, m_inv);
      chk("a3",     bus3.a, r3.a);            chk("b3",    bus3.b, r3.b);
      chk("busy3",  bus3.busy, r3.busy);      chk("done3", bus3.done, r3.done);
      chk("pass3",  bus3.pass, r3.pass);      chk("err3",  bus3.err_count, r3.errs);
      chk("fv3",    bus3.fail_valid, r3.fv);  chk("fvec3", bus3.fail_vec, r3.fvec);
      chk("fmask3", bus3.fail_mask, r3.fmask);
      chk("busy1",  bus1.busy, r1.busy);      chk("done1", bus1.done, r1.done);
      chk("pass1",  bus1.pass, r1.pass);      chk("err1",  bus1.err_count, r1.errs);
      chk("fv1",    bus1.fail_valid, r1.fv);  chk("fvec1", bus1.fail_vec, r1.fvec);
      chk("fmask1", bus1.fail_mask, r1.fmask);
    end
  end

  // One run: start sampled at edge 0; optional spurious start / reset at given offsets
  task automatic run(input int spur, input int abort_e);
    logic [1:0] abseen [4];
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int cur = 0; cur <= RUN; cur++) begin
      if (cur % (S + 1) == 0 && cur / (S + 1) < 4) abseen[cur / (S + 1)] = {bus3.a, bus3.b};
      if (cur == RUN) chk("done_before_edge13", bus3.done, 1'b0);
      start = (cur == spur);
      if (cur == abort_e) rst = 1'b1;
      @(negedge clk);
      start = 1'b0;
      if (rst) begin
        rst = 1'b0;
        chk("abort_busy", bus3.busy, 1'b0);
        chk("abort_ab",   {bus3.a, bus3.b}, 2'b00);
        chk("abort_err",  bus3.err_count, 3'd0);
        chk("abort_done", bus3.done, 1'b0);
        chk("abort_fv",   bus3.fail_valid, 1'b0);
        return;
      end
    end
    chk("done_at_edge13", bus3.done, 1'b1);
    for (int k = 0; k < 4; k++) chk("ab_step", abseen[k], k);
  endtask

  initial begin
    int spur, abort_e;
    repeat (2) @(negedge clk);
    cmp_en = 1'b1;
    chk("rst_busy", bus3.busy, 1'b0);
    chk("rst_ab",   {bus3.a, bus3.b}, 2'b00);
    chk("rst_done", bus3.done, 1'b0);
    chk("rst_err",  bus3.err_count, 3'd0);
    rst = 1'b0;
    @(negedge clk);

    run(-1, -1);
    chk("good_pass", bus3.pass, 1'b1);
    chk("good_err",  bus3.err_count, 3'd0);
    chk("good_fv",   bus3.fail_valid, 1'b0);

    f_clr = 7'b0100000;
    run(-1, -1);
    chk("xor_err",   bus3.err_count, 3'd2);
    chk("xor_fvec",  bus3.fail_vec, 2'b01);
    chk("xor_fmask", bus3.fail_mask, 7'b0100000);
    chk("xor_pass",  bus3.pass, 1'b0);
    chk("xor_err_w1", bus1.err_count, 1'b1);

    f_clr = '0;
    run(-1, -1);
    chk("b2b_pass", bus3.pass, 1'b1);
    chk("b2b_fv",   bus3.fail_valid, 1'b0);

    run(4, -1);
    chk("spur_pass", bus3.pass, 1'b1);

    f_clr = 7'b0100000;
    run(-1, 6);
    f_clr = '0;
    run(-1, -1);
    chk("post_rst_pass", bus3.pass, 1'b1);

    f_inv = 7'h7F;
    run(-1, -1);
    chk("inv_err_w1",   bus1.err_count, 1'b1);
    chk("inv_fmask_w1", bus1.fail_mask, 7'h7F);
    chk("inv_fvec_w1",  bus1.fail_vec, 2'b00);
    chk("inv_pass_w1",  bus1.pass, 1'b0);
    chk("inv_err3",     bus3.err_count, 3'd4);
    f_inv = '0;

    for (int i = 0; i < 25; i++) begin
      if ($urandom_range(0, 2) == 0) begin
        f_clr = '0; f_inv = '0;
      end else begin
        f_clr = 7'($urandom) & 7'($urandom);
        f_inv = 7'($urandom) & 7'($urandom);
      end
      spur    = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, RUN - 1)) : -1;
      abort_e = ($urandom_range(0, 4) == 0) ? int'($urandom_range(0, RUN - 1)) : -1;
      run(spur, abort_e);
      repeat ($urandom_range(0, 3)) @(negedge clk);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end

endmodule
